// File: rtl/call_button_frontend.sv
// Hall-call button front end: per-button synchronizer, debounce/stuck FSM,
// and request/lamp generation gated by the car's current service condition.
module call_button_frontend #(
   parameter int DEB_CYCLES   = 4,
   parameter int STUCK_CYCLES = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn,
   input  logic [1:0] floor,
   input  logic       door,
   output logic [3:0] req,
   output logic [3:0] lamp,
   output logic [3:0] fault
);

   localparam logic [3:0] DEB_C   = 4'(DEB_CYCLES);
   localparam logic [7:0] STUCK_C = 8'(STUCK_CYCLES);

   typedef enum logic [2:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT,
      STUCK
   } state_t;

   logic [3:0] sync1_q, sync2_q;
   state_t     state_q [4];
   state_t     state_d [4];
   logic [3:0] deb_q   [4];
   logic [3:0] deb_d   [4];
   logic [7:0] hold_q  [4];
   logic [7:0] hold_d  [4];
   logic [7:0] hold_inc[4];
   logic [3:0] accept;
   logic [3:0] svc;
   logic [3:0] req_q, req_d;
   logic [3:0] lamp_q, lamp_d;
   logic [3:0] fault_q, fault_d;

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         state_d[i]  = state_q[i];
         deb_d[i]    = deb_q[i];
         hold_d[i]   = hold_q[i];
         hold_inc[i] = (hold_q[i] == 8'hFF) ? 8'hFF : hold_q[i] + 8'd1;
         accept[i]   = 1'b0;
         fault_d[i]  = fault_q[i];
         case (state_q[i])
            RELEASED: begin
               if (sync2_q[i]) begin
                  // A single-sample debounce accepts on the very first high sample.
                  if (DEB_C == 4'd1) begin
                     state_d[i] = PRESSED;
                     hold_d[i]  = '0;
                     deb_d[i]   = '0;
                     accept[i]  = 1'b1;
                  end else begin
                     state_d[i] = PRESS_WAIT;
                     deb_d[i]   = 4'd1;
                  end
               end
            end
            PRESS_WAIT: begin
               if (!sync2_q[i]) begin
                  state_d[i] = RELEASED;
                  deb_d[i]   = '0;
               end else if (deb_q[i] + 4'd1 == DEB_C) begin
                  state_d[i] = PRESSED;
                  hold_d[i]  = '0;
                  deb_d[i]   = '0;
                  accept[i]  = 1'b1;
               end else begin
                  deb_d[i] = deb_q[i] + 4'd1;
               end
            end
            PRESSED: begin
               hold_d[i] = hold_inc[i];
               if (!sync2_q[i]) begin
                  if (DEB_C == 4'd1) begin
                     state_d[i] = RELEASED;
                     deb_d[i]   = '0;
                  end else begin
                     state_d[i] = RELEASE_WAIT;
                     deb_d[i]   = 4'd1;
                  end
               end else if (hold_inc[i] >= STUCK_C) begin
                  // >= so a hold resumed from RELEASE_WAIT past the limit still trips.
                  state_d[i] = STUCK;
                  deb_d[i]   = '0;
                  fault_d[i] = 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (sync2_q[i]) begin
                  state_d[i] = PRESSED;
                  deb_d[i]   = '0;
               end else if (deb_q[i] + 4'd1 == DEB_C) begin
                  state_d[i] = RELEASED;
                  deb_d[i]   = '0;
               end else begin
                  deb_d[i] = deb_q[i] + 4'd1;
               end
            end
            STUCK: begin
               if (sync2_q[i]) begin
                  deb_d[i] = '0;
               end else if (deb_q[i] + 4'd1 == DEB_C) begin
                  state_d[i] = RELEASED;
                  deb_d[i]   = '0;
                  fault_d[i] = 1'b0;
               end else begin
                  deb_d[i] = deb_q[i] + 4'd1;
               end
            end
            default: begin
               state_d[i] = RELEASED;
               deb_d[i]   = '0;
            end
         endcase
      end
   end

   // Service clears the lamp and swallows any accept for the same floor.
   always_comb begin
      req_d  = '0;
      lamp_d = lamp_q;
      svc    = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         svc[i]   = door && (floor == 2'(i));
         req_d[i] = accept[i] && !svc[i];
         if (svc[i]) begin
            lamp_d[i] = 1'b0;
         end else if (accept[i]) begin
            lamp_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         state_q <= '{default: RELEASED};
         deb_q   <= '{default: '0};
         hold_q  <= '{default: '0};
         req_q   <= '0;
         lamp_q  <= '0;
         fault_q <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         state_q <= state_d;
         deb_q   <= deb_d;
         hold_q  <= hold_d;
         req_q   <= req_d;
         lamp_q  <= lamp_d;
         fault_q <= fault_d;
      end
   end

   assign req   = req_q;
   assign lamp  = lamp_q;
   assign fault = fault_q;

endmodule
